// File: rtl/star_pkg.sv
// Shared constants and state encoding for the STAR softmax normalising divider.
package star_pkg;

  localparam int DATA_W  = 32;
  localparam int FRAC_W  = 16;
  localparam int ROW_LEN = 16;
  localparam int ADDR_W  = 9;

  localparam int ITER_W = $clog2(FRAC_W);
  localparam int CNT_W  = $clog2(ROW_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DIV   = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  localparam logic [1:0] ST_IDLE  = S_IDLE;
  localparam logic [1:0] ST_LOAD  = S_LOAD;
  localparam logic [1:0] ST_DIV   = S_DIV;
  localparam logic [1:0] ST_WRITE = S_WRITE;

  // Result written when the quotient would not fit in Q0.FRAC_W.
  localparam logic [FRAC_W-1:0] Q_SAT = '1;

endpackage

// File: rtl/star_restoring_div.sv
// One combinational restoring-division step: shift remainder, trial-subtract,
// shift the resulting quotient bit into q.
module star_restoring_div
  import star_pkg::*;
(
  input  logic [DATA_W:0]   r,
  input  logic [DATA_W-1:0] sum,
  input  logic [FRAC_W-1:0] q,
  output logic [DATA_W:0]   r_next,
  output logic [FRAC_W-1:0] q_next
);

  logic [DATA_W:0] r_sh;
  logic [DATA_W:0] sum_x;
  logic            ge;

  // r < sum on entry, so r << 1 always fits in DATA_W+1 bits.
  assign r_sh   = r << 1;
  assign sum_x  = {1'b0, sum};
  assign ge     = (r_sh >= sum_x);
  assign r_next = ge ? (r_sh - sum_x) : r_sh;
  assign q_next = (q << 1) | FRAC_W'(ge);

endmodule

// File: rtl/star_norm_div.sv
// Softmax normaliser: exp_i / sum_exp as Q0.FRAC_W via a multi-cycle restoring
// divider, one result per element written to the output memory.
module star_norm_div
  import star_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] sum_exp,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_exp,
  output logic              in_ready,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [FRAC_W-1:0] out_data,
  output logic              sat,
  output logic              div0,
  output logic              row_done,
  output logic              busy
);

  // Handshake: an element is taken on a rising edge where in_valid && in_ready;
  // in_ready is high only in LOAD, so in_exp must be held until that edge.

  logic [1:0]        state_q;
  logic [DATA_W-1:0] sum_q;
  logic [DATA_W:0]   r_q;
  logic [DATA_W:0]   r_next;
  logic [FRAC_W-1:0] q_q;
  logic [FRAC_W-1:0] q_next;
  logic [ITER_W-1:0] iter_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [FRAC_W-1:0] data_q;
  logic              sat_q;
  logic              div0_q;

  logic hs;
  logic last_step;
  logic last_elem;

  star_restoring_div u_step (
    .r      (r_q),
    .sum    (sum_q),
    .q      (q_q),
    .r_next (r_next),
    .q_next (q_next)
  );

  assign hs        = in_valid && (state_q == ST_LOAD);
  assign last_step = (iter_q == ITER_W'(FRAC_W - 1));
  assign last_elem = (cnt_q == CNT_W'(ROW_LEN - 1));

  assign in_ready = (state_q == ST_LOAD);
  assign busy     = (state_q != ST_IDLE);
  assign out_we   = (state_q == ST_WRITE);
  assign row_done = (state_q == ST_WRITE) && last_elem;
  assign out_addr = addr_q;
  assign out_data = data_q;
  assign sat      = sat_q;
  assign div0     = div0_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sum_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      iter_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      sat_q   <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sum_q   <= sum_exp;
            cnt_q   <= '0;
            state_q <= ST_LOAD;
            if (sum_exp == '0) div0_q <= 1'b1;
          end
        end

        ST_LOAD: begin
          if (hs) begin
            // sum == 0 is covered by in_exp >= sum.
            if (in_exp >= sum_q) begin
              data_q  <= Q_SAT;
              sat_q   <= 1'b1;
              state_q <= ST_WRITE;
            end else if (in_exp == '0) begin
              data_q  <= '0;
              state_q <= ST_WRITE;
            end else begin
              r_q     <= {1'b0, in_exp};
              q_q     <= '0;
              iter_q  <= '0;
              state_q <= ST_DIV;
            end
          end
        end

        ST_DIV: begin
          r_q    <= r_next;
          q_q    <= q_next;
          iter_q <= iter_q + 1'b1;
          if (last_step) begin
            data_q  <= q_next;
            state_q <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          addr_q  <= addr_q + 1'b1;
          cnt_q   <= cnt_q + 1'b1;
          state_q <= last_elem ? ST_IDLE : ST_LOAD;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_star_norm_div.sv
// Directed bench for star_norm_div with an expected-write queue checked by a monitor.
module tb_star_norm_div;
  import star_pkg::*;

  localparam int W = 32 + ADDR_W + FRAC_W + 1;

  logic              clk;
  logic              reset;
  logic              start;
  logic [DATA_W-1:0] sum_exp;
  logic              in_valid;
  logic [DATA_W-1:0] in_exp;
  logic              in_ready;
  logic              out_we;
  logic [ADDR_W-1:0] out_addr;
  logic [FRAC_W-1:0] out_data;
  logic              sat;
  logic              div0;
  logic              row_done;
  logic              busy;

  logic [W-1:0]      exp_q[$];
  int                checks   = 0;
  int                failures = 0;
  int                cyc      = 0;
  int                we_count = 0;
  int                elem_idx = 0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic              exp_sat  = 1'b0;
  logic              exp_div0 = 1'b0;

  star_norm_div dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sum_exp  (sum_exp),
    .in_valid (in_valid),
    .in_exp   (in_exp),
    .in_ready (in_ready),
    .out_we   (out_we),
    .out_addr (out_addr),
    .out_data (out_data),
    .sat      (sat),
    .div0     (div0),
    .row_done (row_done),
    .busy     (busy)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // monitor: every write is popped against the expected queue
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] e;
    if (row_done && !out_we) begin
      checks++;
      failures++;
      $display("FAIL row_done_without_we actual=1 required=0");
    end
    if (out_we) begin
      we_count++;
      got = {32'(cyc), out_addr, out_data, row_done};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual=addr %0d data 0x%0h cyc %0d required=none",
                 out_addr, out_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL write actual=cyc %0d addr %0d data 0x%0h rd %0b required=cyc %0d addr %0d data 0x%0h rd %0b",
                   got[W-1 -: 32], got[ADDR_W+FRAC_W:FRAC_W+1], got[FRAC_W:1], got[0],
                   e[W-1 -: 32], e[ADDR_W+FRAC_W:FRAC_W+1], e[FRAC_W:1], e[0]);
        end
      end
    end
  end

  // driver tasks (all called at a falling edge)
  task automatic do_start(input logic [DATA_W-1:0] s);
    start   = 1'b1;
    sum_exp = s;
    @(negedge clk);
    start    = 1'b0;
    elem_idx = 0;
    if (s == '0) exp_div0 = 1'b1;
  endtask

  task automatic send(input logic [DATA_W-1:0] e, input logic [FRAC_W-1:0] d,
                      input int lat, input bit push);
    int n;
    n        = 0;
    in_exp   = e;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout actual=0 required=1");
      in_valid = 1'b0;
      return;
    end
    if (push) begin
      exp_q.push_back({32'(cyc + lat), exp_addr, d, (elem_idx == ROW_LEN - 1)});
      exp_addr = exp_addr + 1'b1;
      elem_idx = (elem_idx + 1) % ROW_LEN;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b0;
    exp_addr = '0;
    elem_idx = 0;
    exp_sat  = 1'b0;
    exp_div0 = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out_we"},   out_we,   0);
    check({tag, "_out_addr"}, out_addr, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_sat"},      sat,      0);
    check({tag, "_div0"},     div0,     0);
    check({tag, "_row_done"}, row_done, 0);
    check({tag, "_busy"},     busy,     0);
    check({tag, "_in_ready"}, in_ready, 0);
  endtask

  initial begin
    int we0;
    reset    = 1'b1;
    start    = 1'b0;
    sum_exp  = '0;
    in_valid = 1'b0;
    in_exp   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_cleared("reset");

    // normal division, saturation, ignored start in LOAD
    do_start(32'd4);
    send(32'd1, 16'h4000, 17, 1);
    send(32'd3, 16'hC000, 17, 1);
    send(32'd5, 16'hFFFF, 1, 1);
    exp_sat = 1'b1;
    drain();
    check("sat_after_overflow", sat, exp_sat);
    check("div0_nonzero_sum", div0, exp_div0);
    check("in_ready_load", in_ready, 1);
    start   = 1'b1;
    sum_exp = 32'd8;
    @(negedge clk);
    start = 1'b0;
    send(32'd2, 16'h8000, 17, 1);
    for (int i = 0; i < 12; i++) send(32'd1, 16'h4000, 17, 1);
    drain();
    check("sat_sticky", sat, exp_sat);
    check("row1_busy", busy, 0);
    check("row1_in_ready", in_ready, 0);
    check("row1_next_addr", out_addr, 16);

    // sum_exp == 0
    do_reset();
    check_cleared("reset2");
    do_start(32'd0);
    send(32'd7, 16'hFFFF, 1, 1);
    exp_sat = 1'b1;
    drain();
    check("div0_set", div0, exp_div0);
    check("sat_div0", sat, exp_sat);

    // zero element, fractional quotients, abort mid-DIV
    do_reset();
    do_start(32'd10);
    send(32'd0, 16'h0000, 1, 1);
    send(32'd5, 16'h8000, 17, 1);
    send(32'd1, 16'h1999, 17, 1);
    send(32'd3, 16'h4CCC, 17, 1);
    drain();
    repeat (3) @(negedge clk);
    check("sat_clear_normal", sat, exp_sat);
    check("out_data_held", out_data, 16'h4CCC);
    check("addr_after_four", out_addr, 4);
    we0 = we_count;
    send(32'd7, 16'h0000, 17, 0);
    repeat (4) @(negedge clk);
    check("busy_in_div", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    exp_addr = '0;
    elem_idx = 0;
    exp_sat  = 1'b0;
    exp_div0 = 1'b0;
    check_cleared("abort");
    reset = 1'b0;
    repeat (25) @(negedge clk);
    check("abort_no_write", 32'(we_count - we0), 0);
    check_cleared("abort_after");

    // 32 full rows to wrap the address
    for (int r = 0; r < 32; r++) begin
      do_start(32'd16);
      for (int i = 0; i < ROW_LEN; i++) send(32'd1, 16'h1000, 17, 1);
      drain();
      if (r == 0) begin
        check("fullrow_busy", busy, 0);
        check("fullrow_addr", out_addr, 16);
      end
    end
    check("wrap_addr", out_addr, 0);
    do_start(32'd16);
    send(32'd1, 16'h1000, 17, 1);
    drain();
    check("post_wrap_addr", out_addr, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/star_norm_div.md
Name: star_norm_div

Overview:
- Downstream stage of the STAR softmax engine. Consumes the per-element exponent values and the row exponent sum that the LUT memory produces during the FindSExp phase.
- Computes each normalised softmax output exp_i / Sum_exp as an unsigned Q0.FRAC_W fraction, using a multi-cycle restoring divider. This replaces the single-cycle divide.
- Writes one result per element into the output memory at an auto-incrementing address, and pulses row_done after ROW_LEN elements.

Parameters:
- DATA_W, 32: width of exp and sum_exp.
- FRAC_W, 16: quotient width; result = floor(exp * 2^FRAC_W / sum_exp).
- ROW_LEN, 16: elements per row, matching the Input_buffer depth.
- ADDR_W, 9: output memory address width, matching data_addr.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high.
- start, input, 1: row-start pulse; captures sum_exp.
- sum_exp, input, DATA_W: row exponent sum.
- in_valid, input, 1: in_exp valid.
- in_exp, input, DATA_W: element exponent value.
- in_ready, output, 1: block can accept in_exp.
- out_we, output, 1: output memory write strobe (1-cycle pulse).
- out_addr, output, ADDR_W: output memory write address.
- out_data, output, FRAC_W: normalised result.
- sat, output, 1: sticky; set when any result saturated (exp >= sum or sum == 0).
- div0, output, 1: sticky; set when sum_exp == 0 was captured.
- row_done, output, 1: 1-cycle pulse after the last element of a row is written.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Reset: the synchronous, active-high reset is the already-decided scheme. Every output and register goes to 0 and the state to IDLE. This includes out_addr, out_data, out_we, sat, div0, row_done, the element counter and the sum register. Reset asserted mid-DIV aborts the division; no out_we follows.
- States: IDLE, LOAD, DIV, WRITE.
- IDLE:
  - in_ready = 0.
  - start = 1: capture sum_exp, clear the element counter, go to LOAD. If sum_exp == 0, set div0.
  - in_valid is ignored.
- LOAD:
  - in_ready = 1; a handshake occurs when in_valid && in_ready.
  - On handshake with sum == 0 or in_exp >= sum: q = all-ones (2^FRAC_W - 1), set sat, go to WRITE.
  - On handshake with in_exp == 0: q = 0, go to WRITE.
  - Otherwise: remainder r = in_exp (DATA_W+1 bits), q = 0, iteration count = 0, go to DIV.
  - start is ignored in LOAD, DIV and WRITE; the captured sum stays fixed for the whole row.
- DIV: one restoring step per cycle, for FRAC_W cycles:
  - r' = r << 1.
  - If r' >= sum: r = r' - sum and q = {q[FRAC_W-2:0], 1}.
  - Else: r = r' and q = {q[FRAC_W-2:0], 0}.
  - After FRAC_W steps, go to WRITE.
- WRITE:
  - For 1 cycle: out_we = 1, out_data = q, out_addr = current address. out_addr increments after the write, mod 2^ADDR_W (511 -> 0 wraps silently).
  - Element counter increments. If it reaches ROW_LEN, pulse row_done in that same cycle and go to IDLE; otherwise go to LOAD.
- Latency, measured from a handshake at cycle T:
  - Normal path: out_we at T+FRAC_W+1 (T+17 by default).
  - Fast paths (saturate, zero): out_we at T+1.
- Throughput: one element per FRAC_W+2 cycles worst case. in_ready is low from DIV until WRITE completes.
- out_data holds its last value between writes. out_addr persists across rows, so row k starts at k*ROW_LEN until wrap.
- sat and div0 are sticky until reset.
- Widths: compare and subtract are done at DATA_W+1 bits. No overflow is possible because r < sum is invariant entering each step.

Decomposition:
- Shared package star_pkg:
  - state enum (IDLE/LOAD/DIV/WRITE);
  - localparams DATA_W, FRAC_W, ROW_LEN, ADDR_W;
  - constant Q_SAT = all-ones.
- One natural sub-module: star_restoring_div. It is a single-step datapath: inputs r, sum, q; outputs r_next, q_next. It is combinational and is instantiated once inside the DIV state register update.

Test Plan:
- Normal division:
  - start with sum_exp=4, then exp=1 -> out_we at T+17, out_data=0x4000, out_addr=0, sat=0.
  - Next element exp=3 -> out_data=0xC000, out_addr=1.
- Saturation: sum_exp=4, exp=5 -> out_we at T+1, out_data=0xFFFF, sat=1. sat remains 1 through later normal elements.
- Zero inputs:
  - sum_exp=0, exp=7 -> div0=1, sat=1, out_data=0xFFFF at T+1.
  - sum_exp=10, exp=0 -> out_data=0x0000 at T+1.
- Full rows: 16 elements of exp=1 with sum_exp=16 -> 16 writes of 0x1000 at addresses 0..15, row_done on the 16th write, then IDLE and busy=0. A second row writes addresses 16..31.
- Address wrap: run 32 rows -> the last write hits address 511; the next row's first write is at address 0.
- Reset and ignored inputs:
  - Assert reset 5 cycles into DIV -> no out_we; all outputs 0; in_ready=0.
  - start pulsed during LOAD -> ignored; the captured sum is unchanged, verified by result value.
